// File: rtl/proc_pipe_pckg.sv
// Shared types and default widths for the processing pipeline stages.
package proc_pipe_pckg;

  typedef enum logic {UNPACK_IDLE, UNPACK_BUSY} unpack_state_t;

  localparam int unsigned PIPE_WORD_WDT = 64;
  localparam int unsigned PIPE_ELEM_WDT = 16;

endpackage

// File: rtl/pipe_word_unpacker.sv
// Serialises FIFO words into ELEMS elements (LSB first) under stall backpressure.
// Optional macro PIPE_WORD_UNPACKER_LAST_EN adds the downstream_elem_last output.
module pipe_word_unpacker
  import proc_pipe_pckg::*;
#(
  parameter int unsigned WORD_WDT = PIPE_WORD_WDT,
  parameter int unsigned ELEM_WDT = PIPE_ELEM_WDT
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [WORD_WDT-1:0] upstream_word,
  input  logic                upstream_word_val,
  output logic                upstream_stall,
  output logic [ELEM_WDT-1:0] downstream_elem,
  output logic                downstream_elem_val,
  input  logic                downstream_stall
`ifdef PIPE_WORD_UNPACKER_LAST_EN
  ,
  output logic                downstream_elem_last
`endif
);

  localparam int unsigned ELEMS   = WORD_WDT / ELEM_WDT;
  localparam int unsigned IDX_WDT = $clog2(ELEMS);
  localparam logic [IDX_WDT-1:0] LAST_IDX = IDX_WDT'(ELEMS - 1);

  if ((WORD_WDT % ELEM_WDT) != 0 || ELEMS < 2) begin : g_bad_widths
    $error("pipe_word_unpacker: WORD_WDT must be a multiple of ELEM_WDT with at least two elements");
  end

  unpack_state_t       state;
  logic [IDX_WDT-1:0]  idx;
  logic [WORD_WDT-1:0] word_q;
  logic [ELEM_WDT-1:0] elem_q;
  logic                val_q;
  logic                is_last;
  logic                issue;
  logic                accept;

  assign is_last        = (idx == LAST_IDX);
  assign issue          = (state == UNPACK_BUSY) && !downstream_stall;
  // A new word is only taken while the last element of the held word leaves.
  assign upstream_stall = (state == UNPACK_BUSY) && !(is_last && !downstream_stall);
  assign accept         = upstream_word_val && !upstream_stall;

`ifdef PIPE_WORD_UNPACKER_LAST_EN
  logic last_q;
  assign downstream_elem_last = last_q;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= UNPACK_IDLE;
      idx    <= '0;
      word_q <= '0;
      elem_q <= '0;
      val_q  <= 1'b0;
`ifdef PIPE_WORD_UNPACKER_LAST_EN
      last_q <= 1'b0;
`endif
    end else begin
      if (issue) begin
        elem_q <= word_q[idx*ELEM_WDT +: ELEM_WDT];
        val_q  <= 1'b1;
`ifdef PIPE_WORD_UNPACKER_LAST_EN
        last_q <= is_last;
`endif
        if (is_last) begin
          idx   <= '0;
          state <= UNPACK_IDLE;
        end else begin
          idx   <= idx + 1'b1;
        end
      end else if (!downstream_stall && state == UNPACK_IDLE) begin
        elem_q <= '0;
        val_q  <= 1'b0;
`ifdef PIPE_WORD_UNPACKER_LAST_EN
        last_q <= 1'b0;
`endif
      end
      // Accept overrides the last-issue return to idle so back-to-back words have no bubble.
      if (accept) begin
        word_q <= upstream_word;
        idx    <= '0;
        state  <= UNPACK_BUSY;
      end
    end
  end

  assign downstream_elem     = elem_q;
  assign downstream_elem_val = val_q;

`ifndef SYNTHESIS
  a_no_early_accept: assert property (@(posedge clk) disable iff (rst)
    !(accept && state == UNPACK_BUSY && !is_last));
  a_idx_range: assert property (@(posedge clk) disable iff (rst)
    32'(idx) < ELEMS);
  a_val_zero: assert property (@(posedge clk) disable iff (rst)
    downstream_elem_val || (downstream_elem == '0));
`endif

endmodule

// File: doc/pipe_word_unpacker.md
Name: pipe_word_unpacker

Overview:
- Pipeline stage directly downstream of the backpressure FIFO.
- Accepts full-width words from the FIFO under stall backpressure and serialises each word into ELEMS narrower elements, one per cycle, for the next processing block.
- Propagates downstream stall back to the FIFO so no word or element is lost or duplicated.

Parameters:
- WORD_WDT, 64: width of the incoming FIFO word.
- ELEM_WDT, 16: width of one output element. WORD_WDT % ELEM_WDT == 0 and WORD_WDT/ELEM_WDT >= 2 are required; check by elaboration-time assertion.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; one clock; asynchronous, active-high.
- upstream_word  in  WORD_WDT  word from FIFO.
- upstream_word_val  in  1  word valid. May stay high across stalled cycles while the FIFO holds the same word.
- upstream_stall  out  1  backpressure to FIFO; combinational from registered state and downstream_stall.
- downstream_elem  out  ELEM_WDT  element; forced to 0 when downstream_elem_val=0.
- downstream_elem_val  out  1  element valid.
- downstream_stall  in  1  backpressure from the consumer.

Behaviour:
- Derived constants: ELEMS = WORD_WDT/ELEM_WDT; IDX_WDT = $clog2(ELEMS).
- Word accept: upstream_word_val & !upstream_stall in the same cycle. On accept, word_q <= upstream_word, idx <= 0, state <= UNPACK.
- FSM states:
  - IDLE: no word held.
  - UNPACK: word held, elements idx..ELEMS-1 pending.
- Issue: a cycle with state==UNPACK & !downstream_stall.
  - On issue: downstream_elem register <= word_q[idx*ELEM_WDT +: ELEM_WDT]; downstream_elem_val <= 1; idx <= idx+1.
  - On the last issue (idx==ELEMS-1): go to IDLE, or stay in UNPACK with the new word if an accept happens in the same cycle (idx <= 0).
- Element order: LSB first; element 0 = bits [ELEM_WDT-1:0].
- Output hold: while downstream_stall=1, downstream_elem and downstream_elem_val hold their values. When !downstream_stall and state==IDLE, downstream_elem_val <= 0.
- upstream_stall = (state==UNPACK) & !(idx==ELEMS-1 & !downstream_stall). In IDLE, stall is 0 even if downstream is stalled.
- Latency: word accepted in cycle N; element 0 visible at N+2 if unstalled. Back-to-back words give one element per cycle with no bubble.
- Reset values (asynchronous assert, synchronous deassert handled upstream): state=IDLE, idx=0, downstream_elem_val=0, downstream_elem=0, word_q=0.
- Reset mid-word: the held word and any remaining elements are discarded; nothing is replayed.
- Boundaries:
  - upstream_word_val high while upstream_stall is high: not an accept, no capture.
  - downstream_stall asserted on the last-element cycle: no accept; the word is held until the stall drops.
- Assertions (translate_off):
  - no accept while state==UNPACK & idx!=ELEMS-1;
  - idx < ELEMS;
  - downstream_elem_val=0 implies downstream_elem=0.

Optional Feature:
- Macro: PIPE_WORD_UNPACKER_LAST_EN.
- Defined: adds output port downstream_elem_last (1 bit).
  - Registered with downstream_elem; high with the element taken from idx==ELEMS-1.
  - Held under stall; 0 on reset and whenever downstream_elem_val=0.
- Undefined: port absent; behaviour otherwise identical.

Decomposition:
- proc_pipe_pckg gets:
  - typedef enum logic {UNPACK_IDLE, UNPACK_BUSY} unpack_state_t;
  - default constants PIPE_WORD_WDT=64 and PIPE_ELEM_WDT=16.
- ELEMS and IDX_WDT are localparams inside the module.
- No sub-module: element select is one indexed part-select, and the FSM is two states.

Test Plan:
- Single word 0x4444_3333_2222_1111 accepted at N, no stall -> elems 0x1111, 0x2222, 0x3333, 0x4444 valid at N+2..N+5; val=0 at N+6; upstream_stall high N+1..N+3, low at N+4.
- Two words back-to-back (second = 0x8888_7777_6666_5555) -> 8 contiguous valid elems 0x1111..0x8888, no bubble; second accept coincides with the 0x4444 issue cycle.
- downstream_stall high for 3 cycles while 0x2222 is on the output -> 0x2222 held with val=1 for 4 cycles total; upstream_stall=1 throughout; no element skipped or duplicated.
- upstream_word_val held high for 5 cycles with the same word while upstream_stall=1 -> captured exactly once; exactly 4 elements emitted.
- rst pulsed asynchronously (mid-cycle) after 0x2222 is issued -> val and idx drop to 0 immediately, upstream_stall=0, no 0x3333/0x4444 emitted; the next word unpacks normally from element 0.
- With PIPE_WORD_UNPACKER_LAST_EN -> downstream_elem_last=1 only with 0x4444 and 0x8888, and it holds under stall.
